// File: rtl/bist_pkg.sv
// Shared types and helpers for the combinational-netlist BIST controllers.
package bist_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} bist_state_e;

  localparam logic [19:0] LFSR20_TAPS = 20'h90000;  // x^20 + x^17 + 1
  localparam logic [9:0]  MISR10_TAPS = 10'h240;    // x^10 + x^7 + 1

  // Shift-register step on a wide container; callers truncate to their own width.
  localparam int unsigned STEP_W = 32;

  function automatic logic [STEP_W-1:0] lfsr_next(input logic [STEP_W-1:0] state,
                                                  input logic [STEP_W-1:0] taps);
    return {state[STEP_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register with synchronous clear and capture enable.
module sig_misr
  import bist_pkg::*;
#(
  parameter int unsigned      N_OUT = 10,
  parameter logic [N_OUT-1:0] TAPS  = MISR10_TAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [N_OUT-1:0] data,
  output logic [N_OUT-1:0] sig
);

  logic [N_OUT-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (enable) begin
      sig_d = N_OUT'(lfsr_next(STEP_W'(sig_q), STEP_W'(TAPS))) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/comb_bist_ctrl.sv
// BIST sequencer: LFSR stimulus with a settle window, MISR response compaction
// and a golden-signature compare for one combinational benchmark netlist.
module comb_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned      N_IN      = 20,
  parameter int unsigned      N_OUT     = 10,
  parameter int unsigned      CNT_W     = 16,
  parameter int unsigned      SETTLE_W  = 4,
  parameter logic [N_IN-1:0]  LFSR_TAPS = LFSR20_TAPS,
  parameter logic [N_OUT-1:0] MISR_TAPS = MISR10_TAPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    pattern_count,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [N_IN-1:0]     seed,
  input  logic [N_OUT-1:0]    expected_sig,
  output logic [N_IN-1:0]     pattern_out,
  input  logic [N_OUT-1:0]    resp_in,
  output logic                busy,
  output logic                done,
  output logic [N_OUT-1:0]    signature,
  output logic                pass
);

  bist_state_e         state_q, state_d;
  logic [N_IN-1:0]     lfsr_q, lfsr_d;
  logic [N_IN-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d, remaining_dec;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [SETTLE_W-1:0] settle_lat_q, settle_lat_d;
  logic                misr_clear, misr_en;

  assign remaining_dec = (remaining_q == '0) ? '0 : remaining_q - CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    pat_d        = pat_q;
    remaining_d  = remaining_q;
    settle_cnt_d = settle_cnt_q;
    settle_lat_d = settle_lat_q;
    misr_clear   = 1'b0;
    misr_en      = 1'b0;

    if (abort) begin
      // Abort beats start; MISR and pattern_out deliberately keep their values.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lfsr_d       = (seed == '0) ? N_IN'(1) : seed;
            misr_clear   = 1'b1;
            remaining_d  = pattern_count;
            settle_lat_d = settle_cycles;
            state_d      = (pattern_count == '0) ? DONE : APPLY;
          end
        end
        APPLY: begin
          pat_d        = lfsr_q;
          settle_cnt_d = settle_lat_q;
          state_d      = (settle_lat_q != '0) ? SETTLE : CAPTURE;
        end
        SETTLE: begin
          if (settle_cnt_q <= SETTLE_W'(1)) begin
            settle_cnt_d = '0;
            state_d      = CAPTURE;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        CAPTURE: begin
          misr_en     = 1'b1;
          lfsr_d      = N_IN'(lfsr_next(STEP_W'(lfsr_q), STEP_W'(LFSR_TAPS)));
          remaining_d = remaining_dec;
          state_d     = (remaining_dec == '0) ? DONE : APPLY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= '0;
      pat_q        <= '0;
      remaining_q  <= '0;
      settle_cnt_q <= '0;
      settle_lat_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pat_q        <= pat_d;
      remaining_q  <= remaining_d;
      settle_cnt_q <= settle_cnt_d;
      settle_lat_q <= settle_lat_d;
    end
  end

  sig_misr #(
    .N_OUT (N_OUT),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (misr_clear),
    .enable (misr_en),
    .data   (resp_in),
    .sig    (signature)
  );

  assign pattern_out = pat_q;
  assign busy        = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CAPTURE);
  assign done        = (state_q == DONE);
  assign pass        = done && (signature == expected_sig);

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Scoreboard bench for comb_bist_ctrl: directed scenarios plus randomized runs
// against an arithmetic model of the LFSR/MISR sequence.
module tb_comb_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern_count = '0;
  logic [3:0]  settle_cycles = '0;
  logic [19:0] seed = '0;
  logic [9:0]  expected_sig = '0;
  logic [19:0] pattern_out;
  logic [9:0]  resp_in;
  logic        busy, done, pass;
  logic [9:0]  signature;

  logic        resp_netlist = 1'b0;
  logic [9:0]  resp_const = '0;

  typedef struct {
    logic [9:0]  sig;
    logic        pass;
    int          busy;
    logic [19:0] last_pat;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [19:0] model_pat = '0;

  always #5 clk = ~clk;

  comb_bist_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern_count (pattern_count),
    .settle_cycles (settle_cycles),
    .seed          (seed),
    .expected_sig  (expected_sig),
    .pattern_out   (pattern_out),
    .resp_in       (resp_in),
    .busy          (busy),
    .done          (done),
    .signature     (signature),
    .pass          (pass)
  );

  // Stand-in for the benchmark netlist: arbitrary fold of the 20 inputs.
  function automatic logic [9:0] netlist(input logic [19:0] p);
    return p[9:0] ^ p[19:10] ^ {p[14:10], p[4:0]} ^ {p[0], p[19:11]};
  endfunction

  always_comb resp_in = resp_netlist ? netlist(pattern_out) : resp_const;

  // Pattern k is the seed advanced k times through x^20+x^17+1; the signature
  // folds each response into a doubling-with-parity register modulo 2^10.
  function automatic exp_t model_run(input logic [19:0] sd, input int cnt, input int st,
                                     input logic [9:0] golden, input logic [19:0] prev,
                                     input bit netl, input logic [9:0] rc, input string name);
    exp_t        e;
    int unsigned l, m, r;
    l = (sd == 0) ? 1 : int'(sd);
    m = 0;
    e.last_pat = prev;
    for (int k = 0; k < cnt; k++) begin
      e.last_pat = 20'(l);
      r = netl ? int'(netlist(20'(l))) : int'(rc);
      m = (((m * 2) % 1024) + ($countones(m & 'h240) % 2)) ^ r;
      l = ((l * 2) % (1 << 20)) + ($countones(l & 'h90000) % 2);
    end
    e.sig  = 10'(m);
    e.pass = (10'(m) == golden);
    e.busy = cnt * (st + 2);
    e.name = name;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic pulse_start(input logic [19:0] sd, input int cnt, input int st,
                             input logic [9:0] golden);
    @(negedge clk);
    seed          = sd;
    pattern_count = 16'(cnt);
    settle_cycles = 4'(st);
    expected_sig  = golden;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected result is queued before the start edge so the monitor can never see done first.
  task automatic run(input logic [19:0] sd, input int cnt, input int st,
                     input logic [9:0] golden, input string name);
    exp_t e;
    e = model_run(sd, cnt, st, golden, model_pat, resp_netlist, resp_const, name);
    sb.push_back(e);
    model_pat = e.last_pat;
    pulse_start(sd, cnt, st, golden);
  endtask

  task automatic wait_done(input int lim, input string name);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask

  initial begin
    exp_t e;
    fork
      begin : monitor
        logic done_prev = 1'b0;
        int   busy_len  = 0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            done_prev = 1'b0;
            busy_len  = 0;
          end else begin
            if (done && !done_prev) begin
              checks++;
              if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done with empty queue, required none");
              end else begin
                exp_t x;
                x = sb.pop_front();
                check({x.name, "_sig"}, 32'(signature), 32'(x.sig));
                check({x.name, "_pass"}, 32'(pass), 32'(x.pass));
                check({x.name, "_busy_len"}, 32'(busy_len), 32'(x.busy));
                check({x.name, "_pattern"}, 32'(pattern_out), 32'(x.last_pat));
              end
              busy_len = 0;
            end else if (busy) begin
              busy_len++;
            end else if (!done) begin
              busy_len = 0;
            end
            done_prev = done;
          end
        end
      end
    join_none

    // Reset state
    #2;
    check("rst_pattern", 32'(pattern_out), 0);
    check("rst_sig", 32'(signature), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single pattern, no settle
    resp_const = 10'h000;
    run(20'h00001, 1, 0, 10'h000, "t1");
    check("t1_apply_pattern", 32'(pattern_out), 0);  // APPLY cycle: not yet registered
    @(negedge clk);
    check("t1_capture_pattern", 32'(pattern_out), 32'h00001);
    wait_done(10, "t1");

    // 2: two patterns, constant response
    resp_const = 10'h001;
    run(20'h00001, 2, 0, 10'h003, "t2");
    @(negedge clk);
    check("t2_first_pattern", 32'(pattern_out), 32'h00001);
    @(negedge clk);
    @(negedge clk);
    check("t2_second_pattern", 32'(pattern_out), 32'h00002);
    wait_done(10, "t2");

    // 3: settle window, failing compare
    resp_const = 10'h3FF;
    run(20'h00001, 1, 3, 10'h3FE, "t3");
    wait_done(20, "t3");
    check("t3_done", 32'(done), 1);

    // start and abort together from DONE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_done", 32'(done), 0);

    // 4: zero-count run and zero-seed substitution
    resp_const = 10'h155;
    run(20'h12345, 0, 2, 10'h000, "t4_zero");
    check("t4_zero_done_next", 32'(done), 1);
    run(20'h00000, 1, 1, 10'h155, "t4_seed0");
    wait_done(20, "t4_seed0");

    // 5: abort in cycle 37 of a 100-pattern run, then a clean short run
    resp_netlist = 1'b1;
    e = model_run(20'hABCDE, 18, 0, 10'h000, model_pat, 1'b1, 10'h000, "t5_abort");
    pulse_start(20'hABCDE, 100, 0, 10'h000);
    repeat (36) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_busy", 32'(busy), 0);
    check("t5_abort_done", 32'(done), 0);
    check("t5_abort_pass", 32'(pass), 0);
    check("t5_abort_sig_kept", 32'(signature), 32'(e.sig));
    check("t5_abort_pattern_kept", 32'(pattern_out), 32'(e.last_pat));
    model_pat = e.last_pat;
    run(20'h0F0F0, 2, 1, 10'h000, "t5_after_abort");
    wait_done(30, "t5_after_abort");

    // start pulse while busy is ignored
    run(20'h31337, 5, 2, 10'h000, "t5_ignored_start");
    repeat (5) @(negedge clk);
    pulse_start(20'h00003, 1, 0, 10'h000);
    wait_done(60, "t5_ignored_start");

    // 6: asynchronous reset mid-SETTLE, then re-run scenario 2
    pulse_start(20'h55555, 1, 10, 10'h000);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pattern", 32'(pattern_out), 0);
    check("t6_rst_sig", 32'(signature), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_pass", 32'(pass), 0);
    model_pat = '0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_netlist = 1'b0;
    resp_const   = 10'h001;
    run(20'h00001, 2, 0, 10'h003, "t6_rerun");
    wait_done(10, "t6_rerun");

    // Randomized runs through the netlist stand-in
    resp_netlist = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [19:0] sd;
      int          cnt, st;
      logic [9:0]  golden;
      sd     = 20'($urandom);
      cnt    = int'($urandom_range(1, 6));
      st     = int'($urandom_range(0, 3));
      e      = model_run(sd, cnt, st, 10'h000, model_pat, 1'b1, 10'h000, "rnd");
      golden = (i % 2 == 0) ? e.sig : e.sig ^ 10'($urandom_range(1, 1023));
      run(sd, cnt, st, golden, $sformatf("rnd%0d", i));
      wait_done(200, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
